// File: rtl/sar_pkg.sv
// Shared types for the successive-approximation search controller.
// The optional early-exit build is selected by the SAR_EARLY_EXIT_EN macro (see sar_search_ctrl).
package sar_pkg;

  localparam int SAR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DONE   = 2'd2
  } sar_state_e;

  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } sar_flags_t;

  // A well-formed comparator response raises exactly one flag.
  function automatic logic flags_onehot(input sar_flags_t f);
    case ({f.eq, f.gt, f.lt})
      3'b100, 3'b010, 3'b001: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sar_bit_step.sv
// One SAR decision: resolve bit k from the comparator flags and build the next probe.
// Purely combinational; the caller owns the bit index and all state.
module sar_bit_step
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF,
  parameter int KW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_work,
  input  logic [KW-1:0]    i_k,
  input  sar_flags_t       i_flags,
  output logic [WIDTH-1:0] o_work_nxt,
  output logic [WIDTH-1:0] o_probe_nxt,
  output logic             o_flag_err
);

  logic [WIDTH-1:0] w_bit_k;
  logic [WIDTH-1:0] w_bit_km1;
  logic             w_keep;

  // Malformed flags clear the bit; shifting the k mask right yields no trial bit below the LSB.
  always_comb begin
    w_bit_k    = WIDTH'(1'b1) << i_k;
    w_bit_km1  = w_bit_k >> 1;
    o_flag_err = ~flags_onehot(i_flags);
    if (o_flag_err) begin
      w_keep = 1'b0;
    end else begin
      w_keep = i_flags.gt | i_flags.eq;
    end
    if (w_keep) begin
      o_work_nxt = i_work | w_bit_k;
    end else begin
      o_work_nxt = i_work;
    end
    o_probe_nxt = o_work_nxt | w_bit_km1;
  end

endmodule

// File: rtl/sar_search_ctrl.sv
// SAR search controller: reconstructs an unknown target MSB-first through an external comparator.
// Define SAR_EARLY_EXIT_EN to finish as soon as the comparator reports a clean equality.
module sar_search_ctrl
  import sar_pkg::*;
#(
  parameter int WIDTH = SAR_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a_eq_b,
  input  logic             a_gt_b,
  input  logic             a_lt_b,
  output logic [WIDTH-1:0] probe,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             err
);

  localparam int KW = $clog2(WIDTH);

  sar_state_e       r_state;
  sar_state_e       w_state_nxt;
  logic [KW-1:0]    r_k;
  logic [KW-1:0]    w_k_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [WIDTH-1:0] r_probe;
  logic [WIDTH-1:0] w_probe_nxt;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             r_err;
  logic             w_err_nxt;

  sar_flags_t       w_flags;
  logic [WIDTH-1:0] w_step_work;
  logic [WIDTH-1:0] w_step_probe;
  logic             w_step_err;
  logic             w_early;

  assign w_flags = '{eq: a_eq_b, gt: a_gt_b, lt: a_lt_b};

  sar_bit_step #(
    .WIDTH (WIDTH),
    .KW    (KW)
  ) u_step (
    .i_work      (r_work),
    .i_k         (r_k),
    .i_flags     (w_flags),
    .o_work_nxt  (w_step_work),
    .o_probe_nxt (w_step_probe),
    .o_flag_err  (w_step_err)
  );

`ifdef SAR_EARLY_EXIT_EN
  assign w_early = (r_state == ST_SEARCH) && ({w_flags.eq, w_flags.gt, w_flags.lt} == 3'b100);
`else
  assign w_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the index counter stops at zero instead of wrapping.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_SEARCH;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if ((r_k == {KW{1'b0}}) || w_early) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Output/datapath next values; start outside IDLE falls through untouched.
  always_comb begin
    w_k_nxt      = r_k;
    w_work_nxt   = r_work;
    w_probe_nxt  = r_probe;
    w_result_nxt = r_result;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_err_nxt    = r_err;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_k_nxt     = KW'(WIDTH - 1);
          w_work_nxt  = {WIDTH{1'b0}};
          w_probe_nxt = WIDTH'(1'b1) << (WIDTH - 1);
          w_busy_nxt  = 1'b1;
          w_err_nxt   = 1'b0;
        end else begin
          w_probe_nxt = {WIDTH{1'b0}};
          w_busy_nxt  = 1'b0;
        end
      end
      ST_SEARCH: begin
        w_busy_nxt  = 1'b1;
        w_work_nxt  = w_step_work;
        w_probe_nxt = w_step_probe;
        w_err_nxt   = r_err | w_step_err;
        if (r_k != {KW{1'b0}}) begin
          w_k_nxt = r_k - KW'(1);
        end else begin
          w_k_nxt = r_k;
        end
        if (w_state_nxt == ST_DONE) begin
          w_done_nxt = 1'b1;
          if (w_early) begin
            w_result_nxt = r_probe;
          end else begin
            w_result_nxt = w_step_work;
          end
        end else begin
          w_done_nxt = 1'b0;
        end
      end
      ST_DONE: begin
        w_probe_nxt = {WIDTH{1'b0}};
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_probe_nxt = {WIDTH{1'b0}};
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any search without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k      <= {KW{1'b0}};
      r_work   <= {WIDTH{1'b0}};
      r_probe  <= {WIDTH{1'b0}};
      r_result <= {WIDTH{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_k      <= w_k_nxt;
      r_work   <= w_work_nxt;
      r_probe  <= w_probe_nxt;
      r_result <= w_result_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign probe  = r_probe;
  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign err    = r_err;

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Scoreboard bench for sar_search_ctrl (WIDTH=4): directed targets, comparator modelled in the bench.
module tb_sar_search_ctrl;

  typedef struct packed {
    logic [3:0] target;
    int         force_cmp;
    int         n;
    logic [3:0] p0, p1, p2, p3;
    logic [3:0] res;
    logic       err;
  } vec_t;

  typedef struct packed {
    logic [3:0] res;
    logic       err;
    int         done_cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic       a_eq_b, a_gt_b, a_lt_b;
  logic [3:0] probe, result;
  logic       busy, done, err;

  logic [3:0] target = 4'd0;
  int         cyc = 0;
  int         force_cyc = -1;
  bit         mon_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  exp_t       exp_q[$];
  logic [3:0] probe_q[$];

  sar_search_ctrl dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a_eq_b (a_eq_b),
    .a_gt_b (a_gt_b),
    .a_lt_b (a_lt_b),
    .probe  (probe),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator model with a per-cycle override that drops all flags.
  always_comb begin
    if (cyc == force_cyc) begin
      a_eq_b = 1'b0; a_gt_b = 1'b0; a_lt_b = 1'b0;
    end else begin
      a_eq_b = (target == probe);
      a_gt_b = (target > probe);
      a_lt_b = (target < probe);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] t, input int fc, input int n,
                              input logic [3:0] p0, input logic [3:0] p1,
                              input logic [3:0] p2, input logic [3:0] p3,
                              input logic [3:0] res, input logic e);
    vec_t v;
    v.target = t; v.force_cmp = fc; v.n = n;
    v.p0 = p0; v.p1 = p1; v.p2 = p2; v.p3 = p3;
    v.res = res; v.err = e;
    return v;
  endfunction

  // Monitor: pops probes during compare cycles and the result on the done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst === 1'b0) begin
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("result", {28'd0, result}, {28'd0, e.res});
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("done_cycle", cyc, e.done_cyc);
          chk("probes_left", probe_q.size(), 32'd0);
          chk("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end else if (busy === 1'b1) begin
        if (probe_q.size() == 0) begin
          chk("extra_compare", {31'd0, busy}, 32'd0);
        end else begin
          chk("probe", {28'd0, probe}, {28'd0, probe_q.pop_front()});
        end
      end else begin
        chk("idle_probe", {28'd0, probe}, 32'd0);
      end
    end
  end

  task automatic issue(input vec_t v);
    exp_t e;
    target = v.target;
    start  = 1'b1;
    e.res = v.res; e.err = v.err; e.done_cyc = cyc + v.n + 1;
    exp_q.push_back(e);
    if (v.n > 0) probe_q.push_back(v.p0);
    if (v.n > 1) probe_q.push_back(v.p1);
    if (v.n > 2) probe_q.push_back(v.p2);
    if (v.n > 3) probe_q.push_back(v.p3);
    force_cyc = (v.force_cmp > 0) ? cyc + v.force_cmp : -1;
  endtask

  task automatic wait_done();
    int t = 0;
    while (done !== 1'b1 && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Runs one search; dup pulses start again in cycles 2 and 3 of the search.
  task automatic run_vec(input vec_t v, input bit dup);
    @(negedge clk);
    issue(v);
    @(negedge clk);
    start = 1'b0;
    if (dup) begin
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v11, v0, v15, v8, v11f, v13f, v5, v6;
    v11  = mk(4'd11, 0, 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, 1'b0);
    v0   = mk(4'd0,  0, 4, 4'd8, 4'd4,  4'd2,  4'd1,  4'd0,  1'b0);
    v15  = mk(4'd15, 0, 4, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15, 1'b0);
    v11f = mk(4'd11, 2, 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, 1'b1);
    v13f = mk(4'd13, 2, 4, 4'd8, 4'd12, 4'd10, 4'd11, 4'd11, 1'b1);
    v5   = mk(4'd5,  0, 4, 4'd8, 4'd4,  4'd6,  4'd5,  4'd5,  1'b0);
`ifdef SAR_EARLY_EXIT_EN
    v8   = mk(4'd8,  0, 1, 4'd8, 4'd0,  4'd0,  4'd0,  4'd8,  1'b0);
    v6   = mk(4'd6,  0, 3, 4'd8, 4'd4,  4'd6,  4'd0,  4'd6,  1'b0);
`else
    v8   = mk(4'd8,  0, 4, 4'd8, 4'd12, 4'd10, 4'd9,  4'd8,  1'b0);
    v6   = mk(4'd6,  0, 4, 4'd8, 4'd4,  4'd6,  4'd7,  4'd6,  1'b0);
`endif

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_probe",  {28'd0, probe},  32'd0);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_result", {28'd0, result}, 32'd0);
    chk("rst_err",    {31'd0, err},    32'd0);
    rst = 1'b0;
    mon_en = 1'b1;

    run_vec(v11, 1'b0);
    run_vec(v0, 1'b0);
    run_vec(v15, 1'b0);
    run_vec(v8, 1'b0);
    run_vec(v11f, 1'b0);
    run_vec(v13f, 1'b0);

    // Reset in cycle 2 of a search aborts it with no done pulse.
    @(negedge clk);
    issue(v11);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    probe_q.delete();
    force_cyc = -1;
    @(negedge clk);
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_probe",  {28'd0, probe},  32'd0);
    chk("abort_result", {28'd0, result}, 32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    chk("abort_err",    {31'd0, err},    32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    run_vec(v11, 1'b0);

    // Starts during an active search are ignored; back-to-back start is accepted.
    run_vec(v5, 1'b1);
    run_vec(v6, 1'b0);

    repeat (4) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    chk("probe_drain", probe_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
